// File: rtl/detector_copo.sv
`default_nettype none
// ============================================================================
// Module      : detector_copo
// Description : Ultrasonic (HC-SR04 style) cup detector in front of the
//               juice-dispenser control unit. Issues trigger pulses, times
//               the echo, converts it to centimetres and debounces a
//               cup-present level over CONFIRMA consecutive readings.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            in   system clock
//   reset            in   asynchronous, active-high reset
//   inicia_medida    in   1 = measure continuously, 0 = stop and clear
//   echo             in   raw sensor echo (asynchronous)
//   trigger          out  sensor trigger pulse
//   copo_posicionado out  debounced cup-present level
//   distancia_cm     out  last completed measurement [DIST_W]
//   medida_pronta    out  1-clock pulse per completed measurement
//   erro_timeout     out  1-clock pulse when the echo never rose
//   db_estado        out  current FSM state code (0xE for illegal codes)
// ============================================================================
module detector_copo #(
  parameter int TRIG_CYCLES  = 500,
  parameter int TICKS_PER_CM = 2941,
  parameter int DIST_W       = 9,
  parameter int LIMIAR_CM    = 10,
  parameter int CONFIRMA     = 3,
  parameter int ESPERA_MAX   = 1_500_000,
  parameter int INTERVALO    = 3_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inicia_medida,
  input  logic              echo,
  output logic              trigger,
  output logic              copo_posicionado,
  output logic [DIST_W-1:0] distancia_cm,
  output logic              medida_pronta,
  output logic              erro_timeout,
  output logic [3:0]        db_estado
);

  // One shared counter serves TRIGGER, ESPERA and INTERVALO.
  localparam int c_MAX_A   = (TRIG_CYCLES > ESPERA_MAX) ? TRIG_CYCLES : ESPERA_MAX;
  localparam int c_CNT_MAX = (c_MAX_A > INTERVALO) ? c_MAX_A : INTERVALO;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_TICK_W  = $clog2(TICKS_PER_CM + 1);
  localparam int c_CONF_W  = $clog2(CONFIRMA + 1);

  localparam logic [DIST_W-1:0]   c_DIST_MAX = {DIST_W{1'b1}};
  localparam logic [DIST_W-1:0]   c_LIMIAR   = DIST_W'(LIMIAR_CM);
  localparam logic [c_CONF_W-1:0] c_CONFIRMA = c_CONF_W'(CONFIRMA);

  localparam logic [3:0] c_OCIOSO    = 4'd0;
  localparam logic [3:0] c_TRIGGER   = 4'd1;
  localparam logic [3:0] c_ESPERA    = 4'd2;
  localparam logic [3:0] c_MEDE      = 4'd3;
  localparam logic [3:0] c_AVALIA    = 4'd4;
  localparam logic [3:0] c_INTERVALO = 4'd5;
  localparam logic [3:0] c_ILEGAL    = 4'hE;

  logic [3:0]          r_estado;
  logic [3:0]          w_prox;
  logic                r_echo_meta;
  logic                r_echo_s;
  logic                r_echo_prev;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_TICK_W-1:0] r_tick;
  logic [DIST_W-1:0]   r_cm;
  logic                r_timeout;
  logic [c_CONF_W-1:0] r_conf;
  logic [DIST_W-1:0]   r_dist;
  logic                r_pronta;
  logic                r_erro;
  logic                r_copo;

  logic                w_subida;
  logic                w_trig_fim;
  logic                w_espera_fim;
  logic                w_interv_fim;
  logic                w_tick_wrap;
  logic [c_TICK_W-1:0] w_tick_prox;
  logic [DIST_W-1:0]   w_cm_prox;
  logic                w_mede_sai;
  logic                w_presente;
  logic [c_CONF_W-1:0] w_conf_prox;

  // --------------------------------------------------------------------------
  // Echo synchronizer plus one extra stage for rise detection
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_echo_meta <= 1'b0;
      r_echo_s    <= 1'b0;
      r_echo_prev <= 1'b0;
    end else begin
      r_echo_meta <= echo;
      r_echo_s    <= r_echo_meta;
      r_echo_prev <= r_echo_s;
    end
  end

  // --------------------------------------------------------------------------
  // Shared combinational helpers
  // --------------------------------------------------------------------------
  assign w_subida     = r_echo_s & ~r_echo_prev;
  assign w_trig_fim   = (r_cnt == c_CNT_W'(TRIG_CYCLES - 1));
  assign w_espera_fim = (r_cnt == c_CNT_W'(ESPERA_MAX - 1));
  assign w_interv_fim = (r_cnt == c_CNT_W'(INTERVALO - 1));

  // One echo-high clock: advance the tick counter, carry into centimetres.
  assign w_tick_wrap = (r_tick == c_TICK_W'(TICKS_PER_CM - 1));
  assign w_tick_prox = w_tick_wrap ? '0 : r_tick + 1'b1;
  assign w_cm_prox   = (w_tick_wrap && (r_cm != c_DIST_MAX)) ? r_cm + 1'b1 : r_cm;

  // Leave MEDE on echo fall or as soon as the count would hit full scale.
  assign w_mede_sai  = ~r_echo_s | (w_cm_prox == c_DIST_MAX);

  assign w_presente  = ~r_timeout & (r_cm <= c_LIMIAR);
  assign w_conf_prox = (r_conf == c_CONFIRMA) ? r_conf : r_conf + 1'b1;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= c_OCIOSO;
    else       r_estado <= w_prox;
  end

  // --------------------------------------------------------------------------
  // FSM: next state (dropping inicia_medida wins in every state)
  // --------------------------------------------------------------------------
  always_comb begin
    w_prox = r_estado;
    if (!inicia_medida) begin
      w_prox = c_OCIOSO;
    end else begin
      case (r_estado)
        c_OCIOSO:    w_prox = c_TRIGGER;
        c_TRIGGER:   if (w_trig_fim) w_prox = c_ESPERA;
        c_ESPERA: begin
          if (w_subida)          w_prox = c_MEDE;
          else if (w_espera_fim) w_prox = c_AVALIA;
        end
        c_MEDE:      if (w_mede_sai) w_prox = c_AVALIA;
        c_AVALIA:    w_prox = c_INTERVALO;
        c_INTERVALO: if (w_interv_fim) w_prox = c_TRIGGER;
        default:     w_prox = c_OCIOSO;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs decoded from state (trigger drops with async reset)
  // --------------------------------------------------------------------------
  always_comb begin
    trigger   = (r_estado == c_TRIGGER);
    db_estado = r_estado;
    if (r_estado > c_INTERVALO) db_estado = c_ILEGAL;
  end

  // --------------------------------------------------------------------------
  // Datapath: counters, result registers and confirmation logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_tick    <= '0;
      r_cm      <= '0;
      r_timeout <= 1'b0;
      r_conf    <= '0;
      r_dist    <= '0;
      r_pronta  <= 1'b0;
      r_erro    <= 1'b0;
      r_copo    <= 1'b0;
    end else begin
      r_pronta <= 1'b0;
      r_erro   <= 1'b0;
      case (r_estado)
        c_TRIGGER: begin
          r_cnt     <= w_trig_fim ? '0 : r_cnt + 1'b1;
          r_tick    <= '0;
          r_cm      <= '0;
          r_timeout <= 1'b0;
        end
        c_ESPERA: begin
          if (w_subida) begin
            // The rise clock is itself the first echo-high clock.
            r_cnt  <= '0;
            r_tick <= w_tick_prox;
            r_cm   <= w_cm_prox;
          end else if (w_espera_fim) begin
            r_cnt     <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_MEDE: begin
          if (r_echo_s) begin
            r_tick <= w_tick_prox;
            r_cm   <= w_cm_prox;
          end
        end
        c_AVALIA: begin
          r_cnt    <= '0;
          r_dist   <= r_timeout ? c_DIST_MAX : r_cm;
          r_pronta <= 1'b1;
          r_erro   <= r_timeout;
          if (w_presente) begin
            r_conf <= w_conf_prox;
            r_copo <= (w_conf_prox == c_CONFIRMA);
          end else begin
            r_conf <= '0;
            r_copo <= 1'b0;
          end
        end
        c_INTERVALO: begin
          r_cnt     <= w_interv_fim ? '0 : r_cnt + 1'b1;
          r_tick    <= '0;
          r_cm      <= '0;
          r_timeout <= 1'b0;
        end
        default: begin
          r_cnt     <= '0;
          r_tick    <= '0;
          r_cm      <= '0;
          r_timeout <= 1'b0;
        end
      endcase
      // Stop request: abort, clear debounce; a finishing AVALIA still
      // publishes its distance and pulse above.
      if (!inicia_medida) begin
        r_cnt  <= '0;
        r_conf <= '0;
        r_copo <= 1'b0;
      end
    end
  end

  assign distancia_cm     = r_dist;
  assign medida_pronta    = r_pronta;
  assign erro_timeout     = r_erro;
  assign copo_posicionado = r_copo;

endmodule
`default_nettype wire

// File: tb/tb_detector_copo.sv
`default_nettype none
// ============================================================================
// Module      : tb_detector_copo
// Description : Self-checking bench for detector_copo with a reading-level
//               reference model (distance, timeout and debounce rules).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_detector_copo;

  localparam int c_TRIG  = 4;
  localparam int c_TPC   = 10;
  localparam int c_LIM   = 10;
  localparam int c_CONF  = 3;
  localparam int c_EMAX  = 100;
  localparam int c_INTV  = 50;
  localparam int c_DW    = 6;
  localparam int c_DMAX  = 63;

  logic            clock = 1'b0;
  logic            reset;
  logic            inicia_medida;
  logic            echo;
  logic            trigger;
  logic            copo_posicionado;
  logic [c_DW-1:0] distancia_cm;
  logic            medida_pronta;
  logic            erro_timeout;
  logic [3:0]      db_estado;

  int tests_run = 0;
  int failed    = 0;

  // Reference model state
  int              m_conf = 0;
  bit              m_copo = 1'b0;
  logic [c_DW-1:0] m_last_dist = '0;

  always #5 clock = ~clock;

  detector_copo #(
    .TRIG_CYCLES (c_TRIG),
    .TICKS_PER_CM(c_TPC),
    .DIST_W      (c_DW),
    .LIMIAR_CM   (c_LIM),
    .CONFIRMA    (c_CONF),
    .ESPERA_MAX  (c_EMAX),
    .INTERVALO   (c_INTV)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .inicia_medida   (inicia_medida),
    .echo            (echo),
    .trigger         (trigger),
    .copo_posicionado(copo_posicionado),
    .distancia_cm    (distancia_cm),
    .medida_pronta   (medida_pronta),
    .erro_timeout    (erro_timeout),
    .db_estado       (db_estado)
  );

  // One full measurement: wait for the trigger, apply an echo of len clocks
  // (len=0: no echo) starting dly clocks after the trigger ends, then compare
  // the first result against the model.
  task automatic run_and_check(input string name, input int dly, input int len);
    int n;
    int k;
    int lat;
    bit seen;
    logic [c_DW-1:0] d;
    logic e;
    logic c;
    int exp_d;
    bit exp_to;
    bit pres;
    seen = 1'b0; lat = 0; d = '0; e = 1'b0; c = 1'b0;
    n = 0;
    while (trigger !== 1'b1 && n < 500) begin @(negedge clock); n++; end
    tests_run++;
    if (trigger !== 1'b1) begin
      failed++;
      $display("FAIL %s trigger_start: trigger=%b required 1 within 500 clocks", name, trigger);
    end
    n = 0;
    while (trigger === 1'b1 && n < 50) begin @(negedge clock); n++; end
    tests_run++;
    if (n != c_TRIG) begin
      failed++;
      $display("FAIL %s trigger_width: got %0d clocks required %0d", name, n, c_TRIG);
    end
    k = 0;
    while ((!seen || k < dly + len) && k < dly + len + 400) begin
      echo = (len > 0) && (k >= dly) && (k < dly + len);
      @(negedge clock);
      k++;
      if (!seen && medida_pronta === 1'b1) begin
        seen = 1'b1; lat = k; d = distancia_cm; e = erro_timeout; c = copo_posicionado;
      end
    end
    echo = 1'b0;

    exp_to = (len == 0);
    exp_d  = exp_to ? c_DMAX : ((len / c_TPC > c_DMAX) ? c_DMAX : len / c_TPC);
    pres   = !exp_to && (exp_d <= c_LIM);
    if (pres) begin
      if (m_conf < c_CONF) m_conf++;
      m_copo = (m_conf == c_CONF);
    end else begin
      m_conf = 0;
      m_copo = 1'b0;
    end
    m_last_dist = c_DW'(exp_d);

    tests_run++;
    if (seen !== 1'b1) begin
      failed++;
      $display("FAIL %s medida_pronta: no pulse seen, required one (len=%0d)", name, len);
    end
    tests_run++;
    if (d !== c_DW'(exp_d)) begin
      failed++;
      $display("FAIL %s distancia_cm: got %0d required %0d (len=%0d)", name, d, exp_d, len);
    end
    tests_run++;
    if (e !== exp_to) begin
      failed++;
      $display("FAIL %s erro_timeout: got %b required %b", name, e, exp_to);
    end
    tests_run++;
    if (c !== m_copo) begin
      failed++;
      $display("FAIL %s copo_posicionado: got %b required %b", name, c, m_copo);
    end
    if (exp_to) begin
      tests_run++;
      if (lat != c_EMAX + 1) begin
        failed++;
        $display("FAIL %s timeout_latency: got %0d clocks required %0d", name, lat, c_EMAX + 1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; inicia_medida = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({trigger, copo_posicionado, distancia_cm, medida_pronta, erro_timeout, db_estado} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got trig=%b copo=%b dist=%0d pronta=%b erro=%b estado=%0d required all 0",
               trigger, copo_posicionado, distancia_cm, medida_pronta, erro_timeout, db_estado);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++;
    if (db_estado !== 4'd0 || trigger !== 1'b0) begin
      failed++;
      $display("FAIL post_reset_idle: estado=%0d trig=%b required 0/0", db_estado, trigger);
    end
  endtask

  task automatic test_trigger_idle();
    int w;
    bit any;
    inicia_medida = 1'b1;
    @(negedge clock);
    tests_run++;
    if (trigger !== 1'b1) begin
      failed++;
      $display("FAIL trigger_latency: trigger=%b one clock after start, required 1", trigger);
    end
    w = 0;
    while (trigger === 1'b1 && w < 20) begin w++; @(negedge clock); end
    tests_run++;
    if (w != c_TRIG) begin
      failed++;
      $display("FAIL trigger_first_width: got %0d required %0d", w, c_TRIG);
    end
    inicia_medida = 1'b0;
    any = 1'b0;
    repeat (1000) begin
      @(negedge clock);
      if (trigger === 1'b1) any = 1'b1;
    end
    tests_run++;
    if (any !== 1'b0 || db_estado !== 4'd0) begin
      failed++;
      $display("FAIL idle_no_trigger: trigger_seen=%b estado=%0d required 0/0", any, db_estado);
    end
    m_conf = 0; m_copo = 1'b0;
  endtask

  task automatic test_three_present();
    inicia_medida = 1'b1;
    for (int i = 0; i < 3; i++) run_and_check("present", 3, 55);
  endtask

  task automatic test_absent_clears();
    run_and_check("absent", 2, 150);
    for (int i = 0; i < 3; i++) run_and_check("reconfirm", 4, 55);
  endtask

  task automatic test_threshold();
    run_and_check("limiar_in", 1, 109);
    run_and_check("limiar_out", 1, 110);
  endtask

  task automatic test_timeout();
    run_and_check("timeout", 0, 0);
  endtask

  task automatic test_random();
    int r;
    int len;
    for (int i = 0; i < 14; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)     len = 0;
      else if (r < 7) len = $urandom_range(1, 110);
      else            len = $urandom_range(111, 300);
      run_and_check("random", $urandom_range(0, 20), len);
    end
  endtask

  task automatic test_saturation();
    run_and_check("saturation", 5, 2000);
    inicia_medida = 1'b0;
    repeat (5) @(negedge clock);
    m_conf = 0; m_copo = 1'b0;
  endtask

  task automatic test_abort();
    int n;
    inicia_medida = 1'b1;
    for (int i = 0; i < 3; i++) run_and_check("pre_abort", 2, 55);
    n = 0;
    while (trigger !== 1'b1 && n < 500) begin @(negedge clock); n++; end
    n = 0;
    while (trigger === 1'b1 && n < 50) begin @(negedge clock); n++; end
    echo = 1'b1;
    repeat (30) @(negedge clock);
    tests_run++;
    if (db_estado !== 4'd3) begin
      failed++;
      $display("FAIL abort_setup: estado=%0d required 3", db_estado);
    end
    inicia_medida = 1'b0;
    @(negedge clock);
    echo = 1'b0;
    m_conf = 0; m_copo = 1'b0;
    tests_run++;
    if (db_estado !== 4'd0 || medida_pronta !== 1'b0 || copo_posicionado !== 1'b0) begin
      failed++;
      $display("FAIL abort_state: estado=%0d pronta=%b copo=%b required 0/0/0",
               db_estado, medida_pronta, copo_posicionado);
    end
    tests_run++;
    if (distancia_cm !== m_last_dist) begin
      failed++;
      $display("FAIL abort_dist_hold: got %0d required %0d", distancia_cm, m_last_dist);
    end
    inicia_medida = 1'b1;
    @(negedge clock);
    tests_run++;
    if (trigger !== 1'b1) begin
      failed++;
      $display("FAIL abort_restart: trigger=%b required 1", trigger);
    end
  endtask

  // Entered with trigger high from the abort restart.
  task automatic test_async_reset();
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({trigger, copo_posicionado, distancia_cm, medida_pronta, erro_timeout, db_estado} !== '0) begin
      failed++;
      $display("FAIL async_reset: trig=%b copo=%b dist=%0d pronta=%b erro=%b estado=%0d required all 0",
               trigger, copo_posicionado, distancia_cm, medida_pronta, erro_timeout, db_estado);
    end
    inicia_medida = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_trigger_idle();
    test_three_present();
    test_absent_clears();
    test_threshold();
    test_timeout();
    test_random();
    test_saturation();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
`default_nettype wire
